// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi ACS controller slice.
package viterbi_pkg;

   localparam int N_STATES      = 4;
   localparam int DEF_BM_W      = 2;
   localparam int DEF_PM_W      = 4;
   localparam int DEF_FRAME_LEN = 16;

   typedef enum logic [1:0] {
      IDLE,
      INIT,
      RUN
   } acs_ctrl_state_e;

   typedef logic [DEF_PM_W-1:0] pm_t;

   // Largest PM that still leaves the MSB free for normalisation headroom.
   function automatic int pm_max(input int pm_w);
      return (1 << (pm_w - 1)) - 1;
   endfunction

endpackage

// File: rtl/viterbi_min4.sv
// Combinational argmin over four path metrics; ties resolve to the lowest index.
module viterbi_min4
   import viterbi_pkg::*;
#(
   parameter int PM_W = DEF_PM_W
) (
   input  logic [PM_W-1:0] pm_0,
   input  logic [PM_W-1:0] pm_1,
   input  logic [PM_W-1:0] pm_2,
   input  logic [PM_W-1:0] pm_3,
   output logic [1:0]      idx
);

   logic            lo_sel;
   logic            hi_sel;
   logic [PM_W-1:0] lo_val;
   logic [PM_W-1:0] hi_val;

   // Strict compares keep the lower index on ties at every level.
   always_comb begin
      lo_sel = (pm_1 < pm_0);
      lo_val = lo_sel ? pm_1 : pm_0;
      hi_sel = (pm_3 < pm_2);
      hi_val = hi_sel ? pm_3 : pm_2;
      idx    = (hi_val < lo_val) ? {1'b1, hi_sel} : {1'b0, lo_sel};
   end

endmodule

// File: rtl/viterbi_acs_ctrl.sv
// Frame sequencer around a combinational 4-state ACS unit: BM staging, PM registers, decision forwarding.
// Optional PM normalisation is enabled by defining VITERBI_PM_NORM_EN.
module viterbi_acs_ctrl
   import viterbi_pkg::*;
#(
   parameter int BM_W      = DEF_BM_W,
   parameter int PM_W      = DEF_PM_W,
   parameter int FRAME_LEN = DEF_FRAME_LEN,
   parameter int STEP_W    = $clog2(FRAME_LEN + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [BM_W-1:0]   i_BM_0,
   input  logic [BM_W-1:0]   i_BM_1,
   input  logic [BM_W-1:0]   i_BM_2,
   input  logic [BM_W-1:0]   i_BM_3,
   output logic [BM_W-1:0]   o_BM_0,
   output logic [BM_W-1:0]   o_BM_1,
   output logic [BM_W-1:0]   o_BM_2,
   output logic [BM_W-1:0]   o_BM_3,
   output logic [PM_W-1:0]   o_PM_0,
   output logic [PM_W-1:0]   o_PM_1,
   output logic [PM_W-1:0]   o_PM_2,
   output logic [PM_W-1:0]   o_PM_3,
   input  logic [PM_W-1:0]   i_PM_0,
   input  logic [PM_W-1:0]   i_PM_1,
   input  logic [PM_W-1:0]   i_PM_2,
   input  logic [PM_W-1:0]   i_PM_3,
   input  logic [3:0]        i_dec,
   output logic [3:0]        o_dec,
   output logic              o_dec_valid,
   input  logic              i_tb_ready,
   output logic [STEP_W-1:0] o_step,
   output logic              o_busy,
   output logic              o_frame_done,
   output logic [1:0]        o_best_state
);

   localparam logic [PM_W-1:0]   PM_INIT  = PM_W'(pm_max(PM_W));
   localparam logic [STEP_W-1:0] STEP_END = STEP_W'(FRAME_LEN);

   acs_ctrl_state_e   state_q;
   acs_ctrl_state_e   state_d;
   logic              s1_valid;
   logic [STEP_W-1:0] accept_cnt;
   logic [PM_W-1:0]   pm_q   [N_STATES];
   logic [PM_W-1:0]   pm_new [N_STATES];
   logic              adv;
   logic              accept;
   logic              capture;
   logic              deliver;
   logic              last_deliver;
   logic [1:0]        best_idx;

   assign adv          = !o_dec_valid || i_tb_ready;
   assign accept       = i_valid && o_ready;
   assign capture      = s1_valid && adv;
   assign deliver      = o_dec_valid && i_tb_ready;
   assign last_deliver = deliver && (o_step == STEP_END - STEP_W'(1));

   assign o_PM_0 = pm_q[0];
   assign o_PM_1 = pm_q[1];
   assign o_PM_2 = pm_q[2];
   assign o_PM_3 = pm_q[3];

   always_comb begin
      pm_new[0] = i_PM_0;
      pm_new[1] = i_PM_1;
      pm_new[2] = i_PM_2;
      pm_new[3] = i_PM_3;
`ifdef VITERBI_PM_NORM_EN
      if (i_PM_0[PM_W-1] && i_PM_1[PM_W-1] && i_PM_2[PM_W-1] && i_PM_3[PM_W-1]) begin
         for (int k = 0; k < N_STATES; k++) pm_new[k][PM_W-1] = 1'b0;
      end
`endif
   end

   viterbi_min4 #(.PM_W(PM_W)) u_min4 (
      .pm_0 (pm_q[0]),
      .pm_1 (pm_q[1]),
      .pm_2 (pm_q[2]),
      .pm_3 (pm_q[3]),
      .idx  (best_idx)
   );

   // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // NOTE: a default assignment ahead of the case keeps this block free of inferred latches.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (i_start) state_d = INIT;
         INIT:    state_d = RUN;
         RUN:     if (last_deliver) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      o_busy  = (state_q == INIT) || (state_q == RUN);
      o_ready = (state_q == RUN) && (accept_cnt < STEP_END) && (!s1_valid || adv);
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         s1_valid     <= 1'b0;
         accept_cnt   <= '0;
         o_BM_0       <= '0;
         o_BM_1       <= '0;
         o_BM_2       <= '0;
         o_BM_3       <= '0;
         o_dec        <= '0;
         o_dec_valid  <= 1'b0;
         o_step       <= '0;
         o_frame_done <= 1'b0;
         o_best_state <= '0;
         // NOTE: the PM bank is four flops, not a RAM, so clearing it in reset costs nothing special.
         for (int k = 0; k < N_STATES; k++) pm_q[k] <= '0;
      end else begin
         o_frame_done <= last_deliver;
         if (state_q == INIT) begin
            pm_q[0] <= '0;
            for (int k = 1; k < N_STATES; k++) pm_q[k] <= PM_INIT;
            o_step     <= '0;
            accept_cnt <= '0;
         end
         if (accept) begin
            o_BM_0     <= i_BM_0;
            o_BM_1     <= i_BM_1;
            o_BM_2     <= i_BM_2;
            o_BM_3     <= i_BM_3;
            accept_cnt <= accept_cnt + STEP_W'(1);
            s1_valid   <= 1'b1;
         end else if (capture) begin
            s1_valid <= 1'b0;
         end
         // Stage 2 only advances when the decision slot is empty or being drained.
         if (capture) begin
            for (int k = 0; k < N_STATES; k++) pm_q[k] <= pm_new[k];
            o_dec       <= i_dec;
            o_dec_valid <= 1'b1;
         end else if (deliver) begin
            o_dec_valid <= 1'b0;
         end
         if (deliver)      o_step       <= o_step + STEP_W'(1);
         if (last_deliver) o_best_state <= best_idx;
      end
   end

endmodule

// File: tb/tb_viterbi_acs_ctrl.sv
// Self-checking bench for viterbi_acs_ctrl: bench-side ACS unit, integer PM reference model, directed + random frames.
module tb_viterbi_acs_ctrl;

   localparam int BM_W      = 2;
   localparam int PM_W      = 4;
   localparam int FRAME_LEN = 16;
   localparam int STEP_W    = $clog2(FRAME_LEN + 1);

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              valid;
   logic              tb_ready;
   logic [7:0]        bm_bus;
   logic [15:0]       ipm;
   logic [3:0]        idec;
   logic [19:0]       acs_r;
   wire  [7:0]        obm;
   wire  [15:0]       opm;
   wire               o_ready;
   wire  [3:0]        o_dec;
   wire               o_dec_valid;
   wire  [STEP_W-1:0] o_step;
   wire               o_busy;
   wire               o_frame_done;
   wire  [1:0]        o_best_state;

   logic              ovr_en;
   logic [15:0]       ovr_pm;

   int                n_checks = 0;
   int                n_errors = 0;
   int                cyc = 0;
   int                mpm [4];
   logic [19:0]       exp_q [$];
   int                n_acc, n_del, n_done, first_hs, first_dv, first_del, last_del;
   bit                in_frame, directed_first;

   always #5 clk = ~clk;

   viterbi_acs_ctrl #(.BM_W(BM_W), .PM_W(PM_W), .FRAME_LEN(FRAME_LEN), .STEP_W(STEP_W)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_start      (start),
      .i_valid      (valid),
      .o_ready      (o_ready),
      .i_BM_0       (bm_bus[1:0]),
      .i_BM_1       (bm_bus[3:2]),
      .i_BM_2       (bm_bus[5:4]),
      .i_BM_3       (bm_bus[7:6]),
      .o_BM_0       (obm[1:0]),
      .o_BM_1       (obm[3:2]),
      .o_BM_2       (obm[5:4]),
      .o_BM_3       (obm[7:6]),
      .o_PM_0       (opm[3:0]),
      .o_PM_1       (opm[7:4]),
      .o_PM_2       (opm[11:8]),
      .o_PM_3       (opm[15:12]),
      .i_PM_0       (ipm[3:0]),
      .i_PM_1       (ipm[7:4]),
      .i_PM_2       (ipm[11:8]),
      .i_PM_3       (ipm[15:12]),
      .i_dec        (idec),
      .o_dec        (o_dec),
      .o_dec_valid  (o_dec_valid),
      .i_tb_ready   (tb_ready),
      .o_step       (o_step),
      .o_busy       (o_busy),
      .o_frame_done (o_frame_done),
      .o_best_state (o_best_state)
   );

   // ACS trellis equations on PM_W-wide wrapping sums; returns {dec[3:0], pm3, pm2, pm1, pm0}.
   function automatic logic [19:0] acs_eval(input logic [7:0] bm, input logic [15:0] pm);
      int b [4];
      int p [4];
      int c1 [4];
      int c2 [4];
      logic [19:0] r;
      r = '0;
      for (int k = 0; k < 4; k++) begin
         b[k] = int'(bm[2*k +: 2]);
         p[k] = int'(pm[4*k +: 4]);
      end
      c1[0] = b[0] + p[0];  c2[0] = b[3] + p[1];
      c1[1] = b[2] + p[2];  c2[1] = b[1] + p[3];
      c1[2] = b[3] + p[0];  c2[2] = b[0] + p[1];
      c1[3] = b[1] + p[2];  c2[3] = b[2] + p[3];
      for (int k = 0; k < 4; k++) begin
         c1[k] = c1[k] % 16;
         c2[k] = c2[k] % 16;
         if (c2[k] < c1[k]) begin
            r[16+k]    = 1'b1;
            r[4*k +: 4] = 4'(c2[k]);
         end else begin
            r[4*k +: 4] = 4'(c1[k]);
         end
      end
      return r;
   endfunction

   function automatic logic [15:0] pack4(input int p [4]);
      return {4'(p[3]), 4'(p[2]), 4'(p[1]), 4'(p[0])};
   endfunction

   function automatic logic [31:0] model_argmin();
      int best = 0;
      for (int k = 1; k < 4; k++) if (mpm[k] < mpm[best]) best = k;
      return 32'(best);
   endfunction

   // The bench acts as the combinational ACS unit, optionally forcing fixed PM results.
   always_comb begin
      acs_r = acs_eval(obm, opm);
      ipm   = ovr_en ? ovr_pm : acs_r[15:0];
      idec  = acs_r[19:16];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   task automatic model_push();
      logic [19:0] r;
      logic [15:0] nxt;
      int p [4];
      r   = acs_eval(bm_bus, pack4(mpm));
      nxt = ovr_en ? ovr_pm : r[15:0];
      for (int k = 0; k < 4; k++) p[k] = int'(nxt[4*k +: 4]);
`ifdef VITERBI_PM_NORM_EN
      if (p[0] >= 8 && p[1] >= 8 && p[2] >= 8 && p[3] >= 8)
         for (int k = 0; k < 4; k++) p[k] = p[k] - 8;
`endif
      mpm = p;
      exp_q.push_back({r[19:16], pack4(p)});
   endtask

   // Sample on the falling edge, then return 1 time unit after the next rising edge.
   task automatic tick();
      logic [19:0] e;
      @(negedge clk);
      if (rst_n) begin
         if (in_frame && n_acc >= FRAME_LEN) check("ready_after_last", 32'(o_ready), 0);
         if (valid && o_ready) begin
            model_push();
            if (n_acc == 0) first_hs = cyc;
            n_acc++;
         end
         if (o_dec_valid && first_dv < 0) begin
            first_dv = cyc;
            check("latency", 32'(first_dv - first_hs), 2);
         end
         if (o_dec_valid && tb_ready) begin
            if (exp_q.size() == 0) begin
               check("dec_extra", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("dec", 32'(o_dec), 32'(e[19:16]));
               check("pm", 32'(opm), 32'(e[15:0]));
               if (directed_first && n_del == 0) begin
                  check("first_dec", 32'(o_dec), 0);
                  check("first_pm", 32'(opm), 32'h7070);
               end
            end
            if (n_del == 0) first_del = cyc;
            last_del = cyc;
            n_del++;
         end
         if (o_frame_done) begin
            n_done++;
            check("done_step", 32'(o_step), FRAME_LEN);
            check("best_state", 32'(o_best_state), model_argmin());
            check("done_count", 32'(n_del), FRAME_LEN);
            check("busy_at_done", 32'(o_busy), 0);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic begin_frame();
      valid    = 1'b0;
      tb_ready = 1'b1;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      mpm      = '{0, 7, 7, 7};
      exp_q.delete();
      n_acc    = 0;
      n_del    = 0;
      n_done   = 0;
      first_hs = -1;
      first_dv = -1;
      in_frame = 1'b1;
      tick();
      check("init_pm", 32'(opm), 32'h7770);
      check("init_busy", 32'(o_busy), 1);
      check("init_ready", 32'(o_ready), 1);
      check("init_step", 32'(o_step), 0);
   endtask

   task automatic run_frame(input int vprob, input int rprob, input bit rand_bm,
                            input bit start_mid, input bit stall);
      bit          stalled = 1'b0;
      logic [3:0]  d0;
      logic [STEP_W-1:0] s0;
      begin_frame();
      for (int t = 0; t < 600 && n_done == 0; t++) begin
         valid    = int'($urandom_range(99)) < vprob;
         tb_ready = int'($urandom_range(99)) < rprob;
         bm_bus   = rand_bm ? 8'($urandom) : 8'h00;
         start    = start_mid && (t == 10);
         if (stall && !stalled && o_dec_valid && n_del >= 4) begin
            stalled = 1'b1;
            d0 = o_dec;
            s0 = o_step;
            for (int s = 0; s < 3; s++) begin
               valid    = 1'b1;
               tb_ready = 1'b0;
               bm_bus   = 8'($urandom);
               tick();
               check("stall_dec", 32'(o_dec), 32'(d0));
               check("stall_step", 32'(o_step), 32'(s0));
               check("stall_dv", 32'(o_dec_valid), 1);
            end
            check("stall_ready", 32'(o_ready), 0);
            tb_ready = 1'b1;
         end
         tick();
      end
      start    = 1'b0;
      valid    = 1'b0;
      in_frame = 1'b0;
      check("frame_done_seen", 32'(n_done), 1);
      check("queue_empty", 32'(exp_q.size()), 0);
      tick();
      check("done_pulse_once", 32'(o_frame_done), 0);
      check("step_hold", 32'(o_step), FRAME_LEN);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_out"}, {o_ready, o_dec_valid, o_busy, o_frame_done, o_dec, o_best_state}, 0);
      check({tag, "_step"}, 32'(o_step), 0);
      check({tag, "_bm"}, 32'(obm), 0);
      check({tag, "_pm"}, 32'(opm), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not terminate");
      $fatal(1);
   end

   initial begin
      rst_n          = 1'b0;
      start          = 1'b0;
      valid          = 1'b0;
      tb_ready       = 1'b0;
      bm_bus         = '0;
      ovr_en         = 1'b0;
      ovr_pm         = '0;
      in_frame       = 1'b0;
      directed_first = 1'b0;
      n_acc = 0; n_del = 0; n_done = 0; first_hs = -1; first_dv = -1;
      repeat (3) tick();
      check_all_zero("reset");
      rst_n = 1'b1;
      tick();
      check("idle_busy", 32'(o_busy), 0);

      // All-zero BMs, continuous flow: latency, first PM update, 16 back-to-back decisions.
      directed_first = 1'b1;
      run_frame(100, 100, 1'b0, 1'b0, 1'b0);
      directed_first = 1'b0;
      check("back_to_back", 32'(last_del - first_del), FRAME_LEN - 1);

      // Random BMs with random handshakes; a start pulse mid-frame must be ignored.
      run_frame(70, 70, 1'b1, 1'b1, 1'b0);
      run_frame(50, 40, 1'b1, 1'b0, 1'b0);

      // Three-cycle traceback stall with BMs still offered.
      run_frame(100, 100, 1'b1, 1'b0, 1'b1);

      // Forced ACS results: all MSBs set, mixed MSBs, and a tie on the minimum.
      ovr_en = 1'b1;
      ovr_pm = 16'hCA98;
      run_frame(100, 100, 1'b1, 1'b0, 1'b0);
`ifdef VITERBI_PM_NORM_EN
      check("norm_pm", 32'(opm), 32'h4210);
`else
      check("raw_pm", 32'(opm), 32'hCA98);
`endif
      ovr_pm = 16'hCA38;
      run_frame(80, 80, 1'b1, 1'b0, 1'b0);
      check("mixed_msb_pm", 32'(opm), 32'hCA38);
      ovr_pm = 16'h6225;
      run_frame(100, 100, 1'b1, 1'b0, 1'b0);
      check("tie_pm", 32'(opm), 32'h6225);
      check("tie_best", 32'(o_best_state), 1);
      ovr_en = 1'b0;

      // Reset in the middle of a frame.
      begin_frame();
      for (int t = 0; t < 100 && o_step < 5; t++) begin
         valid    = 1'b1;
         tb_ready = 1'b1;
         bm_bus   = 8'($urandom);
         tick();
      end
      check("reach_step5", 32'(o_step), 5);
      rst_n = 1'b0;
      tick();
      check_all_zero("mid_reset");
      rst_n    = 1'b1;
      in_frame = 1'b0;
      exp_q.delete();
      valid = 1'b1;
      tick();
      check("post_reset_ready", 32'(o_ready), 0);
      check("post_reset_busy", 32'(o_busy), 0);

      run_frame(80, 80, 1'b1, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/viterbi_acs_ctrl.md
Name: viterbi_acs_ctrl

Overview:
- Sequences one Viterbi frame through the combinational 4-state Add_compare_select_unit.
- Accepts branch metrics (BM) from the BMU over a valid/ready handshake and registers them toward the ACSU.
- Owns the path-metric (PM) registers: initialises them per frame, captures the ACSU results, normalises them, and counts trellis steps.
- Forwards per-step survivor decisions to the traceback unit under back-pressure, and reports the best end state when the frame completes.

Parameters:
- BM_W, 2, branch metric width.
- PM_W, 4, path metric width (must be > BM_W + 1).
- FRAME_LEN, 16, trellis steps per frame (>= 1).
- STEP_W, $clog2(FRAME_LEN+1), step counter width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  synchronous reset, active-low.
- i_start  in  1  frame start request; sampled in IDLE only.
- i_valid  in  1  BM beat valid.
- o_ready  out  1  BM beat accepted when i_valid && o_ready.
- i_BM_0..i_BM_3  in  BM_W each  branch metrics from BMU.
- o_BM_0..o_BM_3  out  BM_W each  registered BMs to ACSU.
- o_PM_0..o_PM_3  out  PM_W each  current PM registers to ACSU.
- i_PM_0..i_PM_3  in  PM_W each  new PMs from ACSU.
- i_dec  in  4  ACSU decisions; bit k = 1 when state k selected its second candidate.
- o_dec  out  4  registered decisions to traceback.
- o_dec_valid  out  1  decision beat valid.
- i_tb_ready  in  1  traceback accepts o_dec.
- o_step  out  STEP_W  decisions delivered in the current frame.
- o_busy  out  1  high in INIT or RUN.
- o_frame_done  out  1  one-cycle pulse after the last decision is delivered.
- o_best_state  out  2  argmin of the PMs at frame end.

Behaviour:
- Reset (synchronous, i_rst_n == 0 at a rising edge), applies in any state including mid-frame:
  - state = IDLE.
  - All o_BM, o_PM, o_dec, o_step, o_best_state = 0.
  - o_ready, o_dec_valid, o_busy, o_frame_done = 0.
  - Internal s1_valid = 0; in-flight beats are discarded.
- IDLE -> INIT on i_start == 1. i_start is ignored in every other state.
- INIT (exactly 1 cycle):
  - Load PM = {0, PM_MAX, PM_MAX, PM_MAX}, with PM_MAX = 2^(PM_W-1) - 1.
  - Clear o_step and the accept counter.
  - Go to RUN.
- RUN, stage 1: o_ready = (accept_cnt < FRAME_LEN) && (!s1_valid || adv), with adv = !o_dec_valid || i_tb_ready. On a handshake:
  - o_BM_x <= i_BM_x.
  - s1_valid <= 1.
  - accept_cnt increments.
- RUN, stage 2: when s1_valid && adv:
  - PM regs <= i_PM_x, normalised when the optional feature is enabled.
  - o_dec <= i_dec.
  - o_dec_valid <= 1.
  - s1_valid clears unless a new beat is accepted in the same cycle.
- Back-to-back beats sustain one step per cycle.
- Latency: handshake at cycle N -> o_dec_valid at N+2.
- o_dec and o_dec_valid hold stable until i_tb_ready. o_step increments on each o_dec_valid && i_tb_ready.
- Frame end: when o_step reaches FRAME_LEN:
  - o_frame_done pulses for 1 cycle.
  - o_best_state = index of the minimum PM; ties go to the lowest index.
  - State -> IDLE. PM registers hold their values.
- The ACSU is combinational. The captured PM is the ACSU output for the current o_BM/o_PM register contents.
- Arithmetic: unsigned. No internal adders beyond normalisation and the counters.

Optional Feature:
- Macro: VITERBI_PM_NORM_EN.
- Defined: at each stage-2 capture, if the MSB of all four i_PM values is 1, each MSB is cleared before storing. This subtracts 2^(PM_W-1) and keeps the PMs bounded.
- Undefined: i_PM values are stored unmodified, and wrap-around is the system's responsibility.

Decomposition:
- Package viterbi_pkg holds:
  - N_STATES = 4.
  - Default widths.
  - The PM_MAX function.
  - typedef enum {IDLE, INIT, RUN} acs_ctrl_state_e.
  - typedef logic [PM_W-1:0] pm_t.
- Sub-module viterbi_min4: combinational argmin of 4 PMs with lowest-index tie-break, used for o_best_state.

Test Plan:
- Bench ACS model equations: PM0 = min(BM0+PM0, BM3+PM1); PM1 = min(BM2+PM2, BM1+PM3); PM2 = min(BM3+PM0, BM0+PM1); PM3 = min(BM1+PM2, BM2+PM3).
1. Reset then i_start: after INIT, o_PM = {0,7,7,7}, o_busy = 1, o_ready = 1. Drive reset low mid-frame at step 5 -> next cycle all outputs 0, state IDLE.
2. All BMs 0, i_tb_ready = 1, bench ACS model (PM_W-wide, equations above) -> first o_dec_valid 2 cycles after the handshake, o_dec = 4'b0000, PM = {0,7,0,7}.
3. Continuous i_valid, FRAME_LEN = 16 -> 16 consecutive decision beats, o_frame_done pulses once at o_step = 16, o_ready low after the 16th accept.
4. i_tb_ready low for 3 cycles with i_valid high -> o_dec held stable, o_ready drops after one beat is buffered in stage 1, no beat lost or duplicated, o_step frozen.
5. Model returns i_PM = {8,9,10,12}:
   - With VITERBI_PM_NORM_EN -> PM = {0,1,2,4}.
   - Without -> {8,9,10,12}.
   - With {8,3,10,12} -> stored unchanged.
6. End PMs {5,2,2,6} -> o_best_state = 1. i_start pulsed during RUN -> ignored, no re-INIT.
